// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg : register map, STATUS bit positions and FSM encoding shared by   |
// |            the UART host-side bus controller.                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam logic [1:0] UART_REG_STATUS = 2'd0;
  localparam logic [1:0] UART_REG_DATA   = 2'd1;
  localparam logic [1:0] UART_REG_CTRL   = 2'd2;
  localparam logic [1:0] UART_REG_CNT    = 2'd3;

  localparam int STAT_RX_DOR = 0;
  localparam int STAT_TX_DIR = 1;
  localparam int STAT_TX_OVF = 2;
  localparam int STAT_RX_UND = 3;
  localparam int STAT_IRQ    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_POP  = 2'd2,
    ST_PUSH = 2'd3
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_bus_ctrl.sv
// +----------------------------------------------------------------------------+
// | uart_bus_ctrl : CPU bus decode for the UART FIFOs; one FIFO pop/push per   |
// |                 CPU access, sticky error flags and a level interrupt.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_bus_ctrl
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cs,
  input  logic       i_rnw,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_irq,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_dor,
  output logic       o_rx_rd,
  output logic [7:0] o_tx_data,
  output logic       o_tx_we,
  input  logic       i_tx_dir
);

  uart_state_t r_state;
  uart_state_t w_next;

  logic       r_rnw;
  logic [1:0] r_addr;
  logic [7:0] r_din;
  logic       r_dor_start;
  logic [7:0] r_dout;
  logic [7:0] r_tx_data;
  logic       r_rxie;
  logic       r_txie;
  logic       r_rx_und;
  logic       r_tx_ovf;
  logic [7:0] r_rxcnt;
  logic [7:0] r_last;

  logic       w_start;
  logic       w_end;
  logic       w_rx_rd;
  logic       w_tx_we;
  logic       w_irq;
  logic [7:0] w_read_val;

  assign w_start = (r_state == ST_IDLE) && i_cs;
  assign w_end   = (r_state == ST_HOLD) && !i_cs;
  assign w_irq   = (r_rxie & i_rx_dor) | (r_txie & i_tx_dir) | r_tx_ovf | r_rx_und;

  always_comb begin
    w_read_val = 8'h00;
    case (i_addr)
      UART_REG_STATUS: begin
        w_read_val[STAT_IRQ]    = w_irq;
        w_read_val[STAT_RX_UND] = r_rx_und;
        w_read_val[STAT_TX_OVF] = r_tx_ovf;
        w_read_val[STAT_TX_DIR] = i_tx_dir;
        w_read_val[STAT_RX_DOR] = i_rx_dor;
      end
      UART_REG_DATA: w_read_val = i_rx_dor ? i_rx_data : r_last;
      UART_REG_CTRL: w_read_val = {6'b000000, r_txie, r_rxie};
      default:       w_read_val = r_rxcnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Pop eligibility is fixed at access start; push eligibility at cs fall.
  always_comb begin
    w_next  = r_state;
    w_rx_rd = 1'b0;
    w_tx_we = 1'b0;
    case (r_state)
      ST_IDLE: if (i_cs) w_next = ST_HOLD;
      ST_HOLD: begin
        if (!i_cs) begin
          if (r_rnw && r_addr == UART_REG_DATA && r_dor_start)
            w_next = ST_POP;
          else if (!r_rnw && r_addr == UART_REG_DATA && i_tx_dir)
            w_next = ST_PUSH;
          else
            w_next = ST_IDLE;
        end
      end
      ST_POP: begin
        w_rx_rd = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_tx_we = 1'b1;
        w_next  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rnw       <= 1'b0;
      r_addr      <= 2'd0;
      r_din       <= 8'h00;
      r_dor_start <= 1'b0;
      r_dout      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_rxie      <= 1'b0;
      r_txie      <= 1'b0;
      r_rx_und    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_rxcnt     <= 8'h00;
      r_last      <= 8'h00;
    end else begin
      if (w_start) begin
        r_rnw       <= i_rnw;
        r_addr      <= i_addr;
        r_din       <= i_din;
        r_dor_start <= i_rx_dor;
        r_dout      <= w_read_val;
        if (i_rnw && i_addr == UART_REG_DATA) begin
          if (i_rx_dor) r_last   <= i_rx_data;
          else          r_rx_und <= 1'b1;
        end
      end
      if (w_end) begin
        r_dout <= 8'h00;
        if (r_rnw && r_addr == UART_REG_STATUS) begin
          r_rx_und <= 1'b0;
          r_tx_ovf <= 1'b0;
        end
        if (!r_rnw) begin
          case (r_addr)
            UART_REG_STATUS: begin
              r_rxie <= r_din[0];
              r_txie <= r_din[1];
            end
            UART_REG_DATA: begin
              if (i_tx_dir) r_tx_data <= r_din;
              else          r_tx_ovf  <= 1'b1;
            end
            UART_REG_CTRL: r_rxcnt <= 8'h00;
            default: ;
          endcase
        end
      end
      if (r_state == ST_POP) r_rxcnt <= r_rxcnt + 8'd1;
    end
  end

  assign o_dout    = r_dout;
  assign o_irq     = w_irq;
  assign o_rx_rd   = w_rx_rd;
  assign o_tx_we   = w_tx_we;
  assign o_tx_data = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_uart_bus_ctrl : self-checking bench for uart_bus_ctrl with a scoreboard |
// |                    of expected read data and FIFO strobes.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_bus_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_cs = 1'b0;
  logic       i_rnw = 1'b1;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_din = 8'h00;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_dor = 1'b0;
  logic       i_tx_dir = 1'b1;
  logic [7:0] o_dout;
  logic       o_irq;
  logic       o_rx_rd;
  logic [7:0] o_tx_data;
  logic       o_tx_we;

  uart_bus_ctrl dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_cs     (i_cs),
    .i_rnw    (i_rnw),
    .i_addr   (i_addr),
    .i_din    (i_din),
    .o_dout   (o_dout),
    .o_irq    (o_irq),
    .i_rx_data(i_rx_data),
    .i_rx_dor (i_rx_dor),
    .o_rx_rd  (o_rx_rd),
    .o_tx_data(o_tx_data),
    .o_tx_we  (o_tx_we),
    .i_tx_dir (i_tx_dir)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         push;
    logic [7:0] data;
  } strb_t;

  strb_t      q_strb[$];
  logic [7:0] q_rd[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Bench model of the architectural state.
  bit       m_rxie, m_txie, m_und, m_ovf;
  bit [7:0] m_cnt, m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit exp_irq();
    return (m_rxie & i_rx_dor) | (m_txie & i_tx_dir) | m_ovf | m_und;
  endfunction

  function automatic logic [7:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0:    return {exp_irq(), 3'b000, m_und, m_ovf, i_tx_dir, i_rx_dor};
      2'd1:    return i_rx_dor ? i_rx_data : m_last;
      2'd2:    return {6'b000000, m_txie, m_rxie};
      default: return m_cnt;
    endcase
  endfunction

  task automatic model_reset();
    m_rxie = 0; m_txie = 0; m_und = 0; m_ovf = 0; m_cnt = 0; m_last = 0;
  endtask

  // Strobe monitor: every strobe must match the oldest expectation.
  bit r_prev_strb = 1'b0;
  always @(negedge i_clk) begin
    if (o_rx_rd === 1'b1 || o_tx_we === 1'b1) begin
      if (q_strb.size() == 0) begin
        chk("strb_unexpected", {30'd0, o_rx_rd, o_tx_we}, 32'd0);
      end else begin
        strb_t e;
        e = q_strb.pop_front();
        chk("strb_kind", {30'd0, o_rx_rd, o_tx_we}, e.push ? 32'd1 : 32'd2);
        if (e.push) chk("tx_data", {24'd0, o_tx_data}, {24'd0, e.data});
      end
      chk("strb_consec", {31'd0, r_prev_strb}, 32'd0);
    end
    r_prev_strb = (o_rx_rd === 1'b1) || (o_tx_we === 1'b1);
  end

  task automatic bus_read(input logic [1:0] a, input int n);
    logic [7:0] exp, got_exp;
    bit pop;
    exp = exp_read(a);
    pop = (a == 2'd1) && i_rx_dor;
    q_rd.push_back(exp);
    if (pop) begin
      q_strb.push_back('{push: 1'b0, data: 8'h00});
      m_last = i_rx_data;
    end else if (a == 2'd1) begin
      m_und = 1;
    end
    i_cs = 1'b1; i_rnw = 1'b1; i_addr = a;
    got_exp = q_rd.pop_front();
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      chk($sformatf("dout_a%0d", a), {24'd0, o_dout}, {24'd0, got_exp});
    end
    i_cs = 1'b0;
    @(posedge i_clk); #1;
    chk("rx_rd_lat", {31'd0, o_rx_rd}, {31'd0, pop});
    chk("dout_idle", {24'd0, o_dout}, 32'd0);
    @(posedge i_clk); #1;
    chk("rx_rd_once", {31'd0, o_rx_rd}, 32'd0);
    if (pop) m_cnt = m_cnt + 8'd1;
    if (a == 2'd0) begin m_und = 0; m_ovf = 0; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int n);
    bit push;
    push = (a == 2'd1) && i_tx_dir;
    if (push) q_strb.push_back('{push: 1'b1, data: d});
    i_cs = 1'b1; i_rnw = 1'b0; i_addr = a; i_din = d;
    repeat (n) @(posedge i_clk);
    #1;
    i_cs = 1'b0;
    @(posedge i_clk); #1;
    chk("tx_we_lat", {31'd0, o_tx_we}, {31'd0, push});
    @(posedge i_clk); #1;
    chk("tx_we_once", {31'd0, o_tx_we}, 32'd0);
    case (a)
      2'd0: begin m_rxie = d[0]; m_txie = d[1]; end
      2'd1: if (!push) m_ovf = 1;
      2'd2: m_cnt = 0;
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("rst_dout", {24'd0, o_dout}, 32'd0);
    chk("rst_strb", {30'd0, o_rx_rd, o_tx_we}, 32'd0);
    chk("rst_txdata", {24'd0, o_tx_data}, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);

    chk("status_const", {24'd0, exp_read(2'd0)}, 32'h02);
    bus_read(2'd0, 1);
    chk("irq_idle", {31'd0, o_irq}, 32'd0);

    // Pop with a held access.
    i_rx_dor = 1'b1; i_rx_data = 8'hA5;
    bus_read(2'd1, 3);
    i_rx_dor = 1'b0;
    bus_read(2'd3, 1);
    chk("rxcnt_one", {24'd0, m_cnt}, 32'd1);

    // Underflow, sticky flag and clear-on-read.
    bus_read(2'd1, 2);
    chk("irq_und", {31'd0, o_irq}, 32'd1);
    i_tx_dir = 1'b0;
    bus_read(2'd0, 1);
    bus_read(2'd0, 1);
    chk("irq_cleared", {31'd0, o_irq}, 32'd0);

    // Push then overflow.
    i_tx_dir = 1'b1;
    bus_write(2'd1, 8'h5A, 2);
    i_tx_dir = 1'b0;
    bus_write(2'd1, 8'hC3, 1);
    chk("irq_ovf", {31'd0, o_irq}, 32'd1);
    chk("txdata_hold", {24'd0, o_tx_data}, 32'h5A);
    bus_read(2'd0, 1);

    // rxie tracks rx_dor.
    bus_write(2'd0, 8'h01, 1);
    bus_read(2'd2, 1);
    for (int k = 0; k < 3; k++) begin
      i_rx_dor = k[0];
      #1;
      chk("irq_rxie", {31'd0, o_irq}, {31'd0, exp_irq()});
    end

    // RXCNT wrap and clear.
    bus_write(2'd2, 8'hFF, 1);
    bus_read(2'd3, 1);
    i_rx_dor = 1'b1;
    for (int k = 0; k < 256; k++) begin
      i_rx_data = k[7:0] ^ 8'h3C;
      bus_read(2'd1, 1);
    end
    bus_read(2'd3, 1);
    chk("rxcnt_wrap", {24'd0, m_cnt}, 32'd0);
    bus_read(2'd1, 1);
    bus_read(2'd3, 1);
    bus_write(2'd2, 8'h00, 1);
    bus_read(2'd3, 1);

    // Reset in the middle of an access: no pop may follow.
    i_rx_dor = 1'b1; i_rx_data = 8'h77;
    i_cs = 1'b1; i_rnw = 1'b1; i_addr = 2'd1;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1; i_cs = 1'b0;
    @(posedge i_clk); #1;
    model_reset();
    chk("abort_rx_rd", {31'd0, o_rx_rd}, 32'd0);
    chk("abort_dout", {24'd0, o_dout}, 32'd0);
    chk("abort_txdata", {24'd0, o_tx_data}, 32'd0);
    chk("abort_irq", {31'd0, o_irq}, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;
    chk("abort_rx_rd2", {31'd0, o_rx_rd}, 32'd0);
    i_rx_dor = 1'b0;
    bus_read(2'd1, 1);
    bus_read(2'd3, 1);
    bus_read(2'd0, 1);

    repeat (2) @(posedge i_clk);
    #1;
    chk("strb_drain", q_strb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_bus_ctrl.md
# uart_bus_ctrl

Host-side controller for the UART receive and transmit FIFOs. It decodes CPU bus accesses into a four-register map and sequences FIFO pops and pushes so that each CPU access causes exactly one FIFO operation. It also keeps sticky error flags and drives a level interrupt. It sits between the 6809 bus glue and the `uartrx`/`uarttx` host ports, and is the only agent that drives `host_rd` on the RX FIFO.

## Interface
- No parameters. Widths are fixed: 8-bit data, 2-bit address.
- clk  in  1  Single system clock; all state changes on rising edge.
- reset  in  1  Synchronous, active-high reset.
- cs  in  1  Chip select; held high for the whole CPU access, for 1 or more cycles.
- rnw  in  1  1 = read, 0 = write; valid while cs is high.
- addr  in  2  Register select; valid while cs is high.
- din  in  8  CPU write data; valid while cs is high.
- dout  out  8  CPU read data.
- irq  out  1  Level interrupt, active-high.
- rx_data  in  8  RX FIFO head byte.
- rx_dor  in  1  RX FIFO data-ready (non-empty).
- rx_rd  out  1  RX FIFO pop strobe, one cycle wide.
- tx_data  out  8  Byte to the TX FIFO.
- tx_we  out  1  TX FIFO push strobe, one cycle wide.
- tx_dir  in  1  TX FIFO has space.

## Operation
- Register map, reads:
  - 0 = STATUS {irq, 0, 0, 0, rx_und, tx_ovf, tx_dir, rx_dor}.
  - 1 = RXDATA.
  - 2 = CTRL readback {000000, txie, rxie}.
  - 3 = RXCNT, the count of bytes popped, 8-bit, wraps 255 -> 0.
- Register map, writes:
  - 0 = CTRL, taking din[1:0].
  - 1 = TXDATA.
  - 2 = clear RXCNT, data ignored.
  - 3 = no effect.
- FSM states: IDLE, HOLD, POP, PUSH.
- IDLE:
  - A cycle with cs high is an access start. It latches rnw/addr/din into the access registers and latches the read value into the dout register.
  - Then go to HOLD.
- HOLD:
  - Remains while cs is high. dout stays frozen at the latched value.
  - On cs low:
    - Latched read of addr 1 with rx_dor high when the access started -> POP.
    - Latched write of addr 1 with tx_dir high (sampled on this cs-low cycle) -> PUSH.
    - Otherwise -> IDLE.
- POP: rx_rd=1 for one cycle; RXCNT increments; -> IDLE.
- PUSH: tx_we=1 for one cycle; tx_data = latched din; -> IDLE.
- RXDATA read while rx_dor=0:
  - Returns the last popped byte, held in an internal register, reset value 0x00.
  - No pop. Sets sticky rx_und.
- TXDATA write while tx_dir=0 at cs low: byte dropped, no push, sets sticky tx_ovf.
- Clearing the sticky flags:
  - A STATUS read clears both rx_und and tx_ovf in the cycle cs falls.
  - The returned value still shows them set.
  - A flag set in that same cycle wins over the clear.
- CTRL and RXCNT writes take effect on the cs-low cycle that ends HOLD.
- irq = (rxie & rx_dor) | (txie & tx_dir) | tx_ovf | rx_und. Combinational from registered state and inputs.
- Back-to-back accesses: cs must be low for at least 1 cycle between accesses. A cs high seen in POP or PUSH is ignored until IDLE. The bus glue guarantees at least 2 low cycles.
- Reset:
  - FSM -> IDLE. CTRL, RXCNT, flags and last-byte register cleared.
  - dout=0x00, rx_rd=0, tx_we=0, tx_data=0x00.
  - irq=0 unless rx_dor/tx_dir force it; with CTRL=0, irq=0.
  - Reset mid-access aborts with no pop or push.

## Timing
- dout is registered. It is valid from the cycle after the access start until cs falls, and is 0x00 in IDLE/POP/PUSH.
- Pop latency: rx_rd is high exactly 1 cycle, 1 cycle after the cs-low cycle. rx_data must stay stable while cs is high.
- Push latency: tx_we is high 1 cycle, 1 cycle after the cs-low cycle. tx_data is valid in the same cycle and holds afterwards.
- At most one of rx_rd or tx_we is high in any cycle. Each is never high for 2 consecutive cycles.
- A 1-cycle cs pulse is a legal access: start, then HOLD sees cs low on the next cycle.

## Structure
- Shared package `uart_pkg`:
  - Register address constants UART_REG_STATUS/DATA/CTRL/CNT.
  - STATUS bit indices.
  - FSM state encoding (2-bit).
- Single module. The read-mux plus latch is simple enough to inline; no sub-module.

## Test plan
- Reset, then read STATUS with rx_dor=0, tx_dir=1 -> dout=0x02, irq=0, no strobes.
- rx_dor=1, rx_data=0xA5; read addr 1 with cs held 3 cycles -> dout=0xA5 throughout the hold; a single rx_rd pulse 1 cycle after cs falls; RXCNT reads 0x01.
- Read addr 1 with rx_dor=0 -> dout equals the previously popped byte, no rx_rd, STATUS bit3=1, irq=1. A second STATUS read returns 0x00 (tx_dir=0, rx_dor=0).
- Write 0x5A to addr 1 with tx_dir=1 -> tx_we for 1 cycle with tx_data=0x5A. Repeat with tx_dir=0 -> no tx_we, tx_ovf=1, irq=1.
- Write CTRL=0x01, then toggle rx_dor 0 -> 1 -> irq follows rx_dor. Perform 256 pops -> RXCNT wraps to 0x00; write addr 2 -> RXCNT clears.
- Assert reset during HOLD of an addr-1 read -> no rx_rd; all outputs at reset values on the next cycle.
